// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW into byte lanes and queues them
// for in-order draining to word-addressed data memory.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_misaligned,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wbe,
  input  logic        mem_ack,
  output logic        empty
);

  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [29:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_be   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic        is_sb;
  logic        is_sh;
  logic        is_sw;
  logic        aligned;
  logic [31:0] f_data;
  logic [3:0]  f_be;
  logic        st_req;
  logic        enq;
  logic        deq;
  logic        mis_q;

  assign is_sb = (st_type == 2'b01);
  assign is_sh = (st_type == 2'b10);
  assign is_sw = (st_type == 2'b11);

  always_comb begin
    aligned = 1'b1;
    f_data  = st_data;
    f_be    = 4'b0000;
    unique case (1'b1)
      is_sb: begin
        f_data = {4{st_data[7:0]}};
        f_be   = 4'b0001 << st_addr[1:0];
      end
      is_sh: begin
        aligned = ~st_addr[0];
        f_data  = {2{st_data[15:0]}};
        f_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      is_sw: begin
        aligned = (st_addr[1:0] == 2'b00);
        f_be    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign st_ready = (count != FULL);
  assign st_req   = st_valid && (st_type != 2'b00) && st_ready;
  assign enq      = st_req && aligned;
  assign mem_req  = (count != '0);
  assign deq      = mem_req && mem_ack;
  assign empty    = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= st_req && !aligned;
      if (enq) tail <= tail + ONE;
      if (deq) head <= head + ONE;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_be[i]   <= '0;
      end
    end else if (enq) begin
      q_addr[tail] <= st_addr[31:2];
      q_data[tail] <= f_data;
      q_be[tail]   <= f_be;
    end
  end

  assign st_misaligned = mis_q;

  assign mem_addr  = mem_req ? {q_addr[head], 2'b00} : '0;
  assign mem_wdata = mem_req ? q_data[head] : '0;
  assign mem_wbe   = mem_req ? q_be[head] : '0;

  // Entry g is live when its distance from head is below count.
  logic [DEPTH-1:0] hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PTR_W-1:0] rel;
    assign rel = PTR_W'(g) - head;
    assign hit[g] = ({1'b0, rel} < count)
                 && (q_addr[g] == ld_addr[31:2]);
  end

  assign ld_conflict = ld_check && (|hit);

  logic unused_ld;
  assign unused_ld = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Inputs change 1 time unit after the rising edge; checks follow.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_misaligned;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbe;
  logic        mem_ack;
  logic        empty;

  int errors = 0;
  int checks = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .st_valid(st_valid),
    .st_type(st_type),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_ready(st_ready),
    .st_misaligned(st_misaligned),
    .ld_check(ld_check),
    .ld_addr(ld_addr),
    .ld_conflict(ld_conflict),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wbe(mem_wbe),
    .mem_ack(mem_ack),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] t,
                     input logic [31:0] a,
                     input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_type  = 2'b00;
    st_addr  = '0;
    st_data  = '0;
    ld_check = 1'b0;
    ld_addr  = '0;
    mem_ack  = 1'b0;
    tick();
    tick();
    check("rst_req", mem_req, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", st_ready, 1);
    check("rst_mis", st_misaligned, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wbe", mem_wbe, 0);
    rst_n = 1'b1;
    tick();

    // 1: SB to byte 3
    mem_ack = 1'b1;
    put(2'b01, 32'h0000_0103, 32'h0000_00A5);
    tick();
    st_valid = 1'b0;
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("t1_wbe", mem_wbe, 4'b1000);
    check("t1_busy", empty, 0);
    tick();
    check("t1_empty", empty, 1);
    check("t1_noreq", mem_req, 0);

    // 2: SH then SW back to back
    put(2'b10, 32'h0000_0022, 32'h1234_BEEF);
    tick();
    put(2'b11, 32'h0000_0040, 32'hCAFE_F00D);
    check("t2a_addr", mem_addr, 32'h20);
    check("t2a_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("t2a_wbe", mem_wbe, 4'b1100);
    tick();
    st_valid = 1'b0;
    check("t2b_addr", mem_addr, 32'h40);
    check("t2b_wdata", mem_wdata, 32'hCAFE_F00D);
    check("t2b_wbe", mem_wbe, 4'b1111);
    tick();
    check("t2_empty", empty, 1);

    // 3: fill while stalled, fifth store refused
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(2'b11, 32'(4 * k), 32'h1000 + 32'(k));
      check($sformatf("t3_ready%0d", k), st_ready, (k < 4) ? 1 : 0);
      tick();
    end
    st_valid = 1'b0;
    check("t3_req", mem_req, 1);
    check("t3_full", st_ready, 0);
    check("t3_hold0", mem_addr, 0);
    tick();
    check("t3_hold1", mem_addr, 0);
    check("t3_holdd", mem_wdata, 32'h1000);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_addr%0d", k), mem_addr, 32'(4 * k));
      check($sformatf("t3_data%0d", k), mem_wdata, 32'h1000 + 32'(k));
      tick();
    end
    check("t3_empty", empty, 1);
    mem_ack = 1'b0;

    // 4: misaligned SW and SH, and a type-00 no-op
    put(2'b11, 32'h0000_0041, 32'h1111_1111);
    tick();
    st_valid = 1'b0;
    check("t4_mis_sw", st_misaligned, 1);
    check("t4_empty_sw", empty, 1);
    tick();
    check("t4_mis_clr", st_misaligned, 0);
    put(2'b10, 32'h0000_0013, 32'h2222_2222);
    tick();
    st_valid = 1'b0;
    check("t4_mis_sh", st_misaligned, 1);
    tick();
    check("t4_mis_clr2", st_misaligned, 0);
    check("t4_noreq", mem_req, 0);
    check("t4_empty", empty, 1);
    put(2'b00, 32'h0000_0041, 32'h3333_3333);
    tick();
    st_valid = 1'b0;
    check("t4_nop_mis", st_misaligned, 0);
    check("t4_nop_empty", empty, 1);

    // 5: load conflict against a pending SW
    put(2'b11, 32'h0000_0080, 32'h5555_5555);
    tick();
    st_valid = 1'b0;
    ld_check = 1'b1;
    ld_addr  = 32'h83;
    #1;
    check("t5_hit", ld_conflict, 1);
    ld_addr = 32'h84;
    #1;
    check("t5_miss", ld_conflict, 0);
    ld_check = 1'b0;
    ld_addr  = 32'h80;
    #1;
    check("t5_off", ld_conflict, 0);
    ld_check = 1'b1;
    mem_ack  = 1'b1;
    #1;
    check("t5_retiring", ld_conflict, 1);
    tick();
    check("t5_gone", ld_conflict, 0);
    ld_check = 1'b0;
    mem_ack  = 1'b0;

    // 6: reset while two SBs are pending
    put(2'b01, 32'h0000_0200, 32'h0000_0011);
    tick();
    put(2'b01, 32'h0000_0201, 32'h0000_0022);
    tick();
    st_valid = 1'b0;
    check("t6_req", mem_req, 1);
    check("t6_addr", mem_addr, 32'h200);
    check("t6_wdata", mem_wdata, 32'h1111_1111);
    check("t6_wbe", mem_wbe, 4'b0001);
    mem_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_after_req", mem_req, 0);
    tick();
    check("t6_after_empty", empty, 1);
    check("t6_after_req2", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
